// File: rtl/pipeline_stall_controller.sv
// Pipeline interlock sequencer: load-use stalls, branch flushes and multdiv freeze/timeout.
// Optional STALL_PERF_COUNTER_EN macro builds a saturating stall-cycle counter.
module pipeline_stall_controller #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_use_hazard,
  input  logic        x_is_mult,
  input  logic        x_is_div,
  input  logic        branch_taken,
  input  logic        multdiv_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        xm_bubble,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_busy,
  output logic        md_timeout,
  output logic [31:0] stall_cycles
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    pc_en         = 1'b0;
    fd_en         = 1'b0;
    dx_en         = 1'b0;
    xm_en         = 1'b0;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    xm_bubble     = 1'b0;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    md_busy       = 1'b0;
    md_timeout    = 1'b0;
    // Outputs are gated by reset so an async reset silences everything at once.
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (x_is_mult || x_is_div) begin
            ctrl_mult     = x_is_mult;
            ctrl_div      = x_is_div && !x_is_mult;
            xm_en         = 1'b1;
            xm_bubble     = 1'b1;
            state_next    = WAIT;
            wait_cnt_next = '0;
          end else if (branch_taken) begin
            {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (load_use_hazard) begin
            dx_en     = 1'b1;
            dx_bubble = 1'b1;
            xm_en     = 1'b1;
          end else begin
            {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
          end
        end
        WAIT: begin
          md_busy = 1'b1;
          if (multdiv_ready) begin
            {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
            state_next    = IDLE;
            wait_cnt_next = '0;
          end else if (wait_cnt_reg == CNT_LAST) begin
            // Abandon: let the pipe advance but discard the stale X/M result.
            md_timeout = 1'b1;
            {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
            xm_bubble     = 1'b1;
            state_next    = IDLE;
            wait_cnt_next = '0;
          end else begin
            xm_en     = 1'b1;
            xm_bubble = 1'b1;
            if (wait_cnt_reg != '1)
              wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (!pc_en && (stall_cnt_reg != 32'hFFFF_FFFF))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; instance a uses MD_TIMEOUT=40, instance b uses 4.
module tb_pipeline_stall_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic load_use_hazard = 1'b0, x_is_mult = 1'b0, x_is_div = 1'b0;
  logic branch_taken = 1'b0, multdiv_ready = 1'b0;

  logic a_pc, a_fd, a_dx, a_xm, a_ff, a_db, a_xb, a_cm, a_cd, a_bz, a_to;
  logic b_pc, b_fd, b_dx, b_xm, b_ff, b_db, b_xb, b_cm, b_cd, b_bz, b_to;
  logic [31:0] a_stall, b_stall;

  int tests = 0;
  int fails = 0;

`ifdef STALL_PERF_COUNTER_EN
  localparam logic [31:0] STALL_AFTER_MULT = 32'd6;
`else
  localparam logic [31:0] STALL_AFTER_MULT = 32'd0;
`endif

  always #5 clock = ~clock;

  pipeline_stall_controller #(.MD_TIMEOUT(40)) dut_a (
    .clock(clock), .reset(reset), .load_use_hazard(load_use_hazard),
    .x_is_mult(x_is_mult), .x_is_div(x_is_div), .branch_taken(branch_taken),
    .multdiv_ready(multdiv_ready), .pc_en(a_pc), .fd_en(a_fd), .dx_en(a_dx),
    .xm_en(a_xm), .fd_flush(a_ff), .dx_bubble(a_db), .xm_bubble(a_xb),
    .ctrl_mult(a_cm), .ctrl_div(a_cd), .md_busy(a_bz), .md_timeout(a_to),
    .stall_cycles(a_stall)
  );

  pipeline_stall_controller #(.MD_TIMEOUT(4)) dut_b (
    .clock(clock), .reset(reset), .load_use_hazard(load_use_hazard),
    .x_is_mult(x_is_mult), .x_is_div(x_is_div), .branch_taken(branch_taken),
    .multdiv_ready(multdiv_ready), .pc_en(b_pc), .fd_en(b_fd), .dx_en(b_dx),
    .xm_en(b_xm), .fd_flush(b_ff), .dx_bubble(b_db), .xm_bubble(b_xb),
    .ctrl_mult(b_cm), .ctrl_div(b_cd), .md_busy(b_bz), .md_timeout(b_to),
    .stall_cycles(b_stall)
  );

  // Packed views: en={pc,fd,dx,xm}, bub={fd_flush,dx_bubble,xm_bubble}, md={mult,div,busy,timeout}
  wire [3:0] a_en  = {a_pc, a_fd, a_dx, a_xm};
  wire [2:0] a_bub = {a_ff, a_db, a_xb};
  wire [3:0] a_md  = {a_cm, a_cd, a_bz, a_to};
  wire [3:0] b_en  = {b_pc, b_fd, b_dx, b_xm};
  wire [2:0] b_bub = {b_ff, b_db, b_xb};
  wire [3:0] b_md  = {b_cm, b_cd, b_bz, b_to};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_en", 32'(a_en), 32'h0);
    chk("reset_bub", 32'(a_bub), 32'h0);
    chk("reset_md", 32'(a_md), 32'h0);
    chk("reset_stall", a_stall, 32'h0);
    cyc();
    reset = 1'b0;

    #2; chk("idle_en", 32'(a_en), 32'hF);
    chk("idle_bub", 32'(a_bub), 32'h0);
    cyc();

    multdiv_ready = 1'b1;
    #2; chk("stray_ready_en", 32'(a_en), 32'hF);
    chk("stray_ready_md", 32'(a_md), 32'h0);
    cyc();
    multdiv_ready = 1'b0;
    #2; chk("stray_ready_after_md", 32'(a_md), 32'h0);
    cyc();

    load_use_hazard = 1'b1;
    #2; chk("lu_en", 32'(a_en), 32'h3);
    chk("lu_bub", 32'(a_bub), 32'h2);
    cyc();
    load_use_hazard = 1'b0;
    #2; chk("lu_after_en", 32'(a_en), 32'hF);
    cyc();

    branch_taken = 1'b1; load_use_hazard = 1'b1;
    #2; chk("br_lu_en", 32'(a_en), 32'hF);
    chk("br_lu_bub", 32'(a_bub), 32'h6);
    cyc();
    branch_taken = 1'b0; load_use_hazard = 1'b0;

    // Multiply with 5-cycle latency: start in cycle 0, ready in cycle 5.
    x_is_mult = 1'b1;
    #2; chk("mul_c0_md", 32'(a_md), 32'h8);
    chk("mul_c0_en", 32'(a_en), 32'h1);
    chk("mul_c0_bub", 32'(a_bub), 32'h1);
    cyc();
    for (int c = 1; c <= 4; c++) begin
      #2; chk($sformatf("mul_c%0d_md", c), 32'(a_md), 32'h2);
      chk($sformatf("mul_c%0d_en", c), 32'(a_en), 32'h1);
      chk($sformatf("mul_c%0d_bub", c), 32'(a_bub), 32'h1);
      cyc();
    end
    multdiv_ready = 1'b1;
    #2; chk("mul_c5_en", 32'(a_en), 32'hF);
    chk("mul_c5_bub", 32'(a_bub), 32'h0);
    chk("mul_c5_md", 32'(a_md), 32'h2);
    cyc();
    multdiv_ready = 1'b0;
    chk("mul_stall_cycles", a_stall, STALL_AFTER_MULT);

    // Back-to-back: a div follows immediately and starts fresh.
    x_is_mult = 1'b0; x_is_div = 1'b1;
    #2; chk("b2b_div_md", 32'(a_md), 32'h4);
    cyc();
    #2; chk("div_c1_md", 32'(a_md), 32'h2);
    cyc();
    #2; chk("div_c2_busy", 32'(a_md), 32'h2);
    reset = 1'b1;
    #1; chk("rst_wait_md", 32'(a_md), 32'h0);
    chk("rst_wait_en", 32'(a_en), 32'h0);
    chk("rst_wait_bub", 32'(a_bub), 32'h0);
    cyc();
    reset = 1'b0;
    #2; chk("rst_restart_md", 32'(a_md), 32'h4);
    cyc();

    x_is_div = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Timeout on instance b (MD_TIMEOUT=4): ready never arrives.
    x_is_div = 1'b1;
    #2; chk("to_c0_md", 32'(b_md), 32'h4);
    cyc();
    for (int c = 1; c <= 3; c++) begin
      #2; chk($sformatf("to_c%0d_md", c), 32'(b_md), 32'h2);
      chk($sformatf("to_c%0d_en", c), 32'(b_en), 32'h1);
      cyc();
    end
    #2; chk("to_c4_md", 32'(b_md), 32'h3);
    chk("to_c4_en", 32'(b_en), 32'hF);
    chk("to_c4_bub", 32'(b_bub), 32'h1);
    chk("to_c4_long_md", 32'(a_md), 32'h2);
    chk("to_c4_long_en", 32'(a_en), 32'h1);
    cyc();
    x_is_div = 1'b0;
    #2; chk("to_c5_md", 32'(b_md), 32'h0);
    chk("to_c5_en", 32'(b_en), 32'hF);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
